wb_hc165: RTL and testbench

WB_HC165 -- requirements
Module: wb_hc165

---
 rtl/hc_shift_pkg.sv | 18 +
 rtl/clk_divider.sv | 33 +++
 rtl/wb_hc165.sv | 136 +++++++++++++
 tb/tb_wb_hc165.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_shift_pkg.sv
// Shared definitions for the 74HC165 shift-in controller: FSM encoding and
// transaction constants.
package hc_shift_pkg;

    localparam int unsigned HC_BITS     = 8;
    localparam int unsigned HC165_TICKS = 24;
    localparam int unsigned HC_CNT_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_CLK_HI = 3'd4,
        ST_CLK_LO = 3'd5
    } hc_state_e;

endpackage

// File: rtl/clk_divider.sv
// Enable-gated divider: tick_c strobes once every RATE enabled cycles and the
// phase restarts from zero whenever enable drops.
module clk_divider #(
    parameter int unsigned RATE  = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick_c = en && (cnt_q == WIDTH'(RATE - 1));

    always_comb begin
        cnt_d = '0;
        if (en && !tick_c) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_hc165.sv
// Wishbone read port for a 74HC165 parallel-in/serial-out register.
// Define WB_HC165_SYNC_EN to pass i_shifter_q7 through a two-flop synchroniser.
module wb_hc165
    import hc_shift_pkg::*;
#(
    parameter int unsigned CLK_DIV_RATE  = 1,
    parameter int unsigned CLK_DIV_WIDTH = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    output logic [7:0] o_wb_data,
    output logic       o_wb_ack,
    output logic       o_wb_stall,
    output logic       o_shifter_pl_n,
    output logic       o_shifter_cp,
    output logic       o_shifter_ce_n,
    input  logic       i_shifter_q7
);

    hc_state_e             state_q, state_d;
    logic [HC_CNT_W-1:0]   cnt_q, cnt_d;
    logic [HC_BITS-1:0]    data_q, data_d;
    logic [HC_BITS-1:0]    rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  stall_q, stall_d;
    logic                  pl_n_q, pl_n_d;
    logic                  cp_q, cp_d;
    logic                  ce_n_q, ce_n_d;
    logic                  tick_c;
    logic                  accept_c;
    logic                  q7_c;

`ifdef WB_HC165_SYNC_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], i_shifter_q7};
    assign q7_c   = sync_q[1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign q7_c = i_shifter_q7;
`endif

    // Divider runs only while a transaction is in flight.
    clk_divider #(
        .RATE  (CLK_DIV_RATE),
        .WIDTH (CLK_DIV_WIDTH)
    ) u_div (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .en     (state_q != ST_IDLE),
        .tick_c (tick_c)
    );

    assign accept_c = (state_q == ST_IDLE) && i_wb_stb && i_wb_cyc && !stall_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD:   if (tick_c) state_d = ST_SETTLE;
            ST_SETTLE: if (tick_c) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (tick_c) begin
                    data_d = {data_q[HC_BITS-2:0], q7_c};
                    cnt_d  = cnt_q + HC_CNT_W'(1);
                    if (cnt_q == HC_CNT_W'(HC_BITS - 1)) begin
                        state_d = ST_IDLE;
                        ack_d   = 1'b1;
                        rdata_d = data_d;
                    end else begin
                        state_d = ST_CLK_HI;
                    end
                end
            end
            ST_CLK_HI: if (tick_c) state_d = ST_CLK_LO;
            ST_CLK_LO: if (tick_c) state_d = ST_SAMPLE;
            default:   state_d = ST_IDLE;
        endcase

        // Pin levels follow the state being entered so they stay flop outputs.
        stall_d = (state_d != ST_IDLE) || ack_d;
        pl_n_d  = (state_d != ST_LOAD);
        cp_d    = (state_d == ST_CLK_HI);
        ce_n_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            pl_n_q  <= 1'b1;
            cp_q    <= 1'b0;
            ce_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            stall_q <= stall_d;
            pl_n_q  <= pl_n_d;
            cp_q    <= cp_d;
            ce_n_q  <= ce_n_d;
        end
    end

    assign o_wb_data      = rdata_q;
    assign o_wb_ack       = ack_q;
    assign o_wb_stall     = stall_q;
    assign o_shifter_pl_n = pl_n_q;
    assign o_shifter_cp   = cp_q;
    assign o_shifter_ce_n = ce_n_q;

endmodule

// File: tb/tb_wb_hc165.sv
// Bench for wb_hc165: two instances (divide-by-1 and divide-by-4) sharing the
// bus strobe, each with a 74HC165 model, checked against a cycle-count model.
module tb_wb_hc165;
    import hc_shift_pkg::*;

    localparam int NL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic stb   = 1'b0;
    logic cyc   = 1'b0;
    logic [NL-1:0][7:0] dev_byte;
    logic [NL-1:0][7:0] wb_data;
    logic [NL-1:0] ack, stall, pl_n, cp, ce_n, q7;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mk = cycles since acceptance (0 = idle and ready).
    int         mk    [NL];
    logic [7:0] mbyte [NL];
    logic [7:0] mdata [NL];

    int w_acks [NL], w_first [NL], w_rise [NL], w_pl_low [NL], w_hi_min [NL], w_hi_max [NL];
    logic [7:0] w_data [NL];

    always #5 clk = ~clk;

    function automatic int rate_of(input int l);
        return (l == 0) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned R = (g == 0) ? 1 : 4;
        localparam int unsigned W = (g == 0) ? 1 : 3;
        logic [7:0] sreg = 8'h00;

        wb_hc165 #(.CLK_DIV_RATE(R), .CLK_DIV_WIDTH(W)) u_dut (
            .i_clk          (clk),
            .i_reset_n      (rst_n),
            .i_wb_cyc       (cyc),
            .i_wb_stb       (stb),
            .o_wb_data      (wb_data[g]),
            .o_wb_ack       (ack[g]),
            .o_wb_stall     (stall[g]),
            .o_shifter_pl_n (pl_n[g]),
            .o_shifter_cp   (cp[g]),
            .o_shifter_ce_n (ce_n[g]),
            .i_shifter_q7   (q7[g])
        );

        // Device: load on PL low, shift towards Q7 on CP rise while CE is low
        always @(negedge pl_n[g] or posedge cp[g]) begin
            if (!pl_n[g]) sreg <= dev_byte[g];
            else if (!ce_n[g]) sreg <= {sreg[6:0], 1'b0};
        end
        assign q7[g] = sreg[7];
    end

    always @(posedge clk or negedge rst_n) begin
        int n;
        for (int l = 0; l < NL; l++) begin
            n = int'(HC165_TICKS) * rate_of(l);
            if (!rst_n) begin
                mk[l]    <= 0;
                mbyte[l] <= 8'h00;
                mdata[l] <= 8'h00;
            end else if (mk[l] == 0) begin
                if (stb && cyc) begin
                    mk[l]    <= 1;
                    mbyte[l] <= dev_byte[l];
                end
            end else if (mk[l] == n + 1) begin
                mk[l] <= 0;
            end else begin
                mk[l] <= mk[l] + 1;
                if (mk[l] == n) mdata[l] <= mbyte[l];
            end
        end
    end

    // Tick j = (k-1)/r; j=0 LOAD, j=1 SETTLE, then SAMPLE/CLK_HI/CLK_LO repeat.
    function automatic void expect_of(input int k, input int r, output logic e_pl_n,
                                      output logic e_cp, output logic e_ce_n,
                                      output logic e_stall, output logic e_ack);
        int j;
        int n;
        n       = int'(HC165_TICKS) * r;
        e_ack   = (k == n + 1);
        e_stall = (k >= 1) && (k <= n + 1);
        e_pl_n  = 1'b1;
        e_cp    = 1'b0;
        e_ce_n  = 1'b1;
        if (k >= 1 && k <= n) begin
            j      = (k - 1) / r;
            e_ce_n = 1'b0;
            e_pl_n = (j != 0);
            e_cp   = (j >= 2) && (((j - 2) % 3) == 1);
        end
    endfunction

    task automatic check(input string name, input int l, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s lane%0d: got %0h want %0h at %0t", name, l, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic e_pl_n, e_cp, e_ce_n, e_stall, e_ack;
        for (int l = 0; l < NL; l++) begin
            expect_of(mk[l], rate_of(l), e_pl_n, e_cp, e_ce_n, e_stall, e_ack);
            check("ack",   l, int'(ack[l]),   int'(e_ack));
            check("stall", l, int'(stall[l]), int'(e_stall));
            check("pl_n",  l, int'(pl_n[l]),  int'(e_pl_n));
            check("cp",    l, int'(cp[l]),    int'(e_cp));
            check("ce_n",  l, int'(ce_n[l]),  int'(e_ce_n));
            check("data",  l, int'(wb_data[l]), int'(mdata[l]));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cmp_all();
    endtask

    // Run n cycles gathering pin statistics; strobe drops after cycle 'hold'.
    task automatic watch(input int n, input int hold);
        int   hi_run [NL];
        logic prev_cp [NL];
        for (int l = 0; l < NL; l++) begin
            w_acks[l] = 0; w_first[l] = 0; w_rise[l] = 0; w_pl_low[l] = 0;
            w_hi_min[l] = 1000; w_hi_max[l] = 0; w_data[l] = 8'h00;
            hi_run[l] = 0; prev_cp[l] = cp[l];
        end
        for (int c = 1; c <= n; c++) begin
            cycle();
            for (int l = 0; l < NL; l++) begin
                if (ack[l]) begin
                    w_acks[l]++;
                    if (w_first[l] == 0) w_first[l] = c;
                    w_data[l] = wb_data[l];
                end
                if (!pl_n[l]) w_pl_low[l]++;
                if (cp[l]) begin
                    if (!prev_cp[l]) w_rise[l]++;
                    hi_run[l]++;
                end else if (hi_run[l] > 0) begin
                    if (hi_run[l] < w_hi_min[l]) w_hi_min[l] = hi_run[l];
                    if (hi_run[l] > w_hi_max[l]) w_hi_max[l] = hi_run[l];
                    hi_run[l] = 0;
                end
                prev_cp[l] = cp[l];
            end
            if (c == hold) stb = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((mk[0] != 0 || mk[1] != 0) && c < budget) begin
            cycle();
            c++;
        end
        check("idle_wait", 0, int'(mk[0] != 0 || mk[1] != 0), 0);
    endtask

    initial begin
        dev_byte = '0;
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single read at both rates
        dev_byte[0] = 8'hA5;
        dev_byte[1] = 8'h3C;
        cyc = 1'b1;
        stb = 1'b1;
        watch(110, 1);
        check("t1_ack_at",  0, w_first[0], 25);
        check("t1_acks",    0, w_acks[0], 1);
        check("t1_data",    0, int'(w_data[0]), 'hA5);
        check("t1_cp_rise", 0, w_rise[0], 7);
        check("t1_pl_low",  0, w_pl_low[0], 1);
        check("t1_ack_at",  1, w_first[1], 97);
        check("t1_data",    1, int'(w_data[1]), 'h3C);
        check("t1_cp_rise", 1, w_rise[1], 7);
        check("t1_pl_low",  1, w_pl_low[1], 4);
        check("t1_hi_min",  1, w_hi_min[1], 4);
        check("t1_hi_max",  1, w_hi_max[1], 4);
        wait_idle(300);

        // Strobe held through the ack cycle must not start a second read
        dev_byte[0] = 8'h96;
        dev_byte[1] = 8'h69;
        stb = 1'b1;
        watch(60, 26);
        check("t2_ack_at", 0, w_first[0], 25);
        check("t2_acks",   0, w_acks[0], 1);
        check("t2_acks",   1, w_acks[1], 0);
        watch(50, 0);
        check("t2_late_acks", 0, w_acks[0], 0);
        check("t2_late_acks", 1, w_acks[1], 1);
        wait_idle(300);

        // Reset during the shift phase
        dev_byte[0] = 8'h5A;
        dev_byte[1] = 8'h5A;
        stb = 1'b1;
        watch(10, 1);
        check("t3_cp_before", 0, int'(cp[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < NL; l++) begin
            check("rst_ack",   l, int'(ack[l]),     0);
            check("rst_stall", l, int'(stall[l]),   0);
            check("rst_data",  l, int'(wb_data[l]), 0);
            check("rst_pl_n",  l, int'(pl_n[l]),    1);
            check("rst_cp",    l, int'(cp[l]),      0);
            check("rst_ce_n",  l, int'(ce_n[l]),    1);
        end
        cmp_all();
        repeat (2) cycle();
        rst_n = 1'b1;
        watch(150, 0);
        check("t3_no_ack", 0, w_acks[0], 0);
        check("t3_no_ack", 1, w_acks[1], 0);
        dev_byte[0] = 8'h81;
        dev_byte[1] = 8'h81;
        stb = 1'b1;
        watch(110, 1);
        for (int l = 0; l < NL; l++) begin
            check("t3_acks", l, w_acks[l], 1);
            check("t3_data", l, int'(w_data[l]), 'h81);
        end
        wait_idle(300);

        // Back-to-back: second strobe in the cycle after the first ack
        dev_byte[0] = 8'hFF;
        dev_byte[1] = 8'hFF;
        stb = 1'b1;
        watch(25, 1);
        check("t4_first_at",   0, w_first[0], 25);
        check("t4_first_data", 0, int'(w_data[0]), 'hFF);
        dev_byte[0] = 8'h00;
        cycle();
        stb = 1'b1;
        watch(30, 1);
        check("t4_second_at",   0, w_first[0], 25);
        check("t4_second_acks", 0, w_acks[0], 1);
        check("t4_second_data", 0, int'(w_data[0]), 'h00);
        wait_idle(300);

        // Random traffic; device bytes only change while a lane is idle
        repeat (3000) begin
            for (int l = 0; l < NL; l++) begin
                if (mk[l] == 0) dev_byte[l] = 8'($urandom);
            end
            stb = ($urandom_range(0, 3) != 0);
            cyc = ($urandom_range(0, 7) != 0);
            cycle();
        end
        stb = 1'b0;
        wait_idle(300);
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
